instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the program ROM address width.
REQ-002 SHALL have parameter INSTR_W, default 40, the instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, the PC value loaded at reset.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rom_addr, output, ADDR_W, the address to program_rom (equals PC register).
REQ-007 SHALL have port rom_data, input, INSTR_W, the program_rom registered output, valid one cycle after the address is sampled.
REQ-008 SHALL have port redirect_valid, input, 1, a branch/jump request.
REQ-009 SHALL have port redirect_pc, input, ADDR_W, the branch/jump target.
REQ-010 SHALL have port instr_valid, output, 1, meaning the decode-side word is valid.
REQ-011 SHALL have port instr_ready, input, 1, meaning decode accepts the word.
REQ-012 SHALL have port instr_data, output, INSTR_W, the instruction word.
REQ-013 SHALL have port instr_pc, output, ADDR_W, the address instr_data was fetched from.

Function
REQ-014 SHALL hold a PC register that drives rom_addr directly, with no combinational path from inputs.
REQ-015 SHALL issue a fetch on an edge when redirect_valid=0 and (fifo_count + inflight - pop) < 2, where pop = instr_valid & instr_ready.
REQ-016 On issue, SHALL set inflight<=1, inflight_pc<=PC, and PC<=PC+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-017 With no issue, SHALL set inflight<=0 and hold PC.
REQ-018 When inflight=1, SHALL push {rom_data, inflight_pc} into a 2-entry FIFO at the next edge.
REQ-019 SHALL guarantee by the issue rule that the FIFO never overflows; push with the FIFO full is an assertion failure.
REQ-020 instr_valid SHALL equal FIFO non-empty; instr_data and instr_pc SHALL be the FIFO head, registered.
REQ-021 Transfer SHALL occur when instr_valid & instr_ready; the head SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged, and preserve order.
REQ-023 redirect_valid=1 SHALL have highest priority: PC<=redirect_pc, inflight<=0 (the returning word is discarded), the FIFO is flushed, and no issue occurs that edge.
REQ-024 During a redirect, instr_valid MAY be 1 that cycle; a handshake in that cycle SHALL count as consumed, and the flush applies after it.
REQ-025 Steady state with instr_ready=1 SHALL sustain one instruction per cycle; the first instr_valid SHALL appear 2 cycles after reset release or a redirect.

Reset
REQ-026 reset_n=0 SHALL asynchronously set PC=RESET_PC, inflight=0, FIFO empty, instr_valid=0, and instr_data=0, instr_pc=0.
REQ-027 Reset mid-operation SHALL discard all in-flight and buffered words; fetch SHALL restart at RESET_PC on the first edge after release.

Structure
REQ-028 ADDR_W, INSTR_W defaults, and the fetch-entry struct {instr, pc} SHALL live in shared package cpu_pkg.
REQ-029 The 2-entry buffer SHALL be sub-module fetch_fifo (push, pop, flush, full, empty, count); PC and issue logic SHALL stay in instr_fetch.
REQ-030 Total RTL SHALL fall within 120-400 lines.

Verification (bench uses a program_rom model, word[a] = {24'hA5A5A5, a})
REQ-031 Reset release with instr_ready=1 -> instr_valid rises at cycle 2 with instr_pc=0x0000, then one word per cycle with pc 1, 2, 3..., and data matching word[pc].
REQ-032 instr_ready=0 for 5 cycles after the first word -> at most 2 words buffered, rom_addr stops advancing, and on release pcs continue without gap or duplicate.
REQ-033 redirect_valid=1, redirect_pc=0x0100 while 2 words are buffered -> those words are never presented after the redirect cycle, and the next instr_pc is 0x0100 two cycles later.
REQ-034 Redirect to 0xFFFE with instr_ready=1 -> instr_pc sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-035 Assert reset_n=0 mid-stream with FIFO full -> instr_valid=0 immediately (asynchronously), and after release instr_pc restarts at RESET_PC.
REQ-036 Random instr_ready toggling for 1000 cycles -> a scoreboard sees contiguous pcs, no loss or duplication, and no FIFO overflow assertion.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch buffer entry.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W  = 16;
  localparam int unsigned CPU_INSTR_W = 40;

  typedef struct packed {
    logic [CPU_INSTR_W-1:0] instr;
    logic [CPU_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer. The head entry is a register, so its fields feed
// decode directly; flush empties the buffer after any same-cycle pop.
module fetch_fifo #(
  parameter type entry_t = cpu_pkg::fetch_entry_t
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  entry_t slot1;
  logic   do_pop;

  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd2);
  assign do_pop = pop & ~empty;

  // Shift organisation: the oldest word always sits in head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      slot1 <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (do_pop) begin
      if (full) begin
        head <= slot1;
        if (push) slot1 <= din;
        else      count <= 2'd1;
      end else begin
        if (push) head  <= din;
        else      count <= 2'd0;
      end
    end else if (push && !full) begin
      if (empty) head  <= din;
      else       slot1 <= din;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register driving a registered program ROM, with
// a two-entry buffer towards decode and redirect/flush handling.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = CPU_ADDR_W,
  parameter int unsigned       INSTR_W  = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              pop;
  logic              push;
  logic              issue;
  logic              full;
  logic              empty;
  logic [1:0]        count;
  entry_t            din;
  entry_t            head;

  assign pop  = instr_valid & instr_ready;
  assign push = inflight & ~redirect_valid;

  // Issue only if the buffer can hold every word already committed to it.
  assign issue = ~redirect_valid &&
                 (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      pc_q        <= pc_q + ADDR_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= pc_q;
    end else begin
      inflight <= 1'b0;
    end
  end

  assign din = {rom_data, inflight_pc};

  fetch_fifo #(.entry_t(entry_t)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     (din),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign rom_addr    = pc_q;
  assign instr_valid = ~empty;
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && full && !pop))
    else $error("instr_fetch: push into full fetch buffer");

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered program ROM model
// whose word at address a is {24'hA5A5A5, a}.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] rom_addr;
  logic [39:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [39:0] instr_data;
  logic [15:0] instr_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(16), .INSTR_W(40), .RESET_PC(16'h0000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [39:0] word(input logic [15:0] a);
    return {24'hA5A5A5, a};
  endfunction

  always @(posedge clock) rom_data <= word(rom_addr);

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    step; step;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    step; step;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
    checks++; if (instr_data !== 40'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", instr_data); end
    checks++; if (instr_pc !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", instr_pc); end
    checks++; if (rom_addr !== 16'h0) begin errors++; $display("FAIL reset_rom_addr: got %h exp 0", rom_addr); end
    reset_n = 1'b1;
    step;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_latency_c1: valid %b exp 0", instr_valid); end
    step;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || instr_data !== word(16'(i))) begin
        errors++; $display("FAIL stream_%0d: valid %b pc %h data %h exp pc %h", i, instr_valid, instr_pc, instr_data, 16'(i));
      end
      step;
    end
  endtask

  task automatic test_stall;
    do_reset;
    step; step;
    step;                    // pc0 accepted, pc1 now at head
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'h0001 || rom_addr !== 16'h0003) begin
        errors++; $display("FAIL stall_%0d: valid %b pc %h rom_addr %h exp pc 0001 rom_addr 0003", i, instr_valid, instr_pc, rom_addr);
      end
    end
    instr_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || instr_data !== word(16'(i))) begin
        errors++; $display("FAIL stall_release_%0d: valid %b pc %h exp %h", i, instr_valid, instr_pc, 16'(i));
      end
      step;
    end
  endtask

  task automatic test_redirect_flush;
    do_reset;
    step; step;
    instr_ready = 1'b0;
    step;                    // pc0 and pc1 buffered
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin errors++; $display("FAIL redir_pre: valid %b pc %h exp 1/0000", instr_valid, instr_pc); end
    redirect_valid = 1'b1; redirect_pc = 16'h0100; instr_ready = 1'b1;
    step;
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || rom_addr !== 16'h0100) begin errors++; $display("FAIL redir_flush: valid %b rom_addr %h exp 0/0100", instr_valid, rom_addr); end
    step;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: valid %b exp 0 (pc %h)", instr_valid, instr_pc); end
    step;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr_data !== word(16'h0100)) begin errors++; $display("FAIL redir_first: valid %b pc %h data %h exp pc 0100", instr_valid, instr_pc, instr_data); end
    step;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0101) begin errors++; $display("FAIL redir_second: valid %b pc %h exp 0101", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hFFFE; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'h0000; exp_seq[3] = 16'h0001;
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step;
    redirect_valid = 1'b0;
    step; step;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_seq[i] || instr_data !== word(exp_seq[i])) begin
        errors++; $display("FAIL wrap_%0d: valid %b pc %h exp %h", i, instr_valid, instr_pc, exp_seq[i]);
      end
      step;
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    step; step;
    instr_ready = 1'b0;
    step; step;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: valid %b exp 1", instr_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr_pc !== 16'h0 || instr_data !== 40'h0 || rom_addr !== 16'h0) begin
      errors++; $display("FAIL areset_async: valid %b pc %h data %h rom_addr %h exp all 0", instr_valid, instr_pc, instr_data, rom_addr);
    end
    @(negedge clock);
    reset_n = 1'b1; instr_ready = 1'b1;
    step;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset_gap: valid %b exp 0", instr_valid); end
    step;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin errors++; $display("FAIL areset_restart: valid %b pc %h exp 1/0000", instr_valid, instr_pc); end
    step;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0001) begin errors++; $display("FAIL areset_next: valid %b pc %h exp 1/0001", instr_valid, instr_pc); end
  endtask

  task automatic test_random_ready;
    logic [15:0] exp_pc;
    logic [15:0] held_pc;
    logic        held;
    int          accepted;
    do_reset;
    step; step;
    exp_pc = 16'h0; held = 1'b0; held_pc = '0; accepted = 0;
    for (int i = 0; i < 1000; i++) begin
      if (held) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== held_pc) begin
          errors++; $display("FAIL rand_hold_%0d: valid %b pc %h exp 1/%h", i, instr_valid, instr_pc, held_pc);
        end
      end
      instr_ready = 1'($urandom_range(0, 1));
      if (instr_valid === 1'b1 && instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc || instr_data !== word(exp_pc)) begin
          errors++; $display("FAIL rand_order_%0d: pc %h data %h exp pc %h", i, instr_pc, instr_data, exp_pc);
        end
        exp_pc = exp_pc + 16'h1;
        accepted++;
        held = 1'b0;
      end else begin
        held = (instr_valid === 1'b1);
        held_pc = instr_pc;
      end
      step;
    end
    checks++;
    if (accepted < 300) begin errors++; $display("FAIL rand_throughput: accepted %0d exp >= 300", accepted); end
    instr_ready = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_stall;
    test_redirect_flush;
    test_wrap;
    test_async_reset;
    test_random_ready;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
